// File: rtl/cnn_mul_arb_pkg.sv
// Shared widths, the pipeline stage record and the product helper for the
// cnn_mul_arb multiplier arbiter.
package cnn_mul_arb_pkg;

  localparam int A_W  = 14;
  localparam int B_W  = 7;
  localparam int P_W  = 21;
  localparam int ID_W = 3;

  // One pipeline slot: valid flag, product and owning requester index.
  typedef struct packed {
    logic                  valid;
    logic signed [P_W-1:0] p;
    logic [ID_W-1:0]       id;
  } stage_t;

  // Exact signed(a) * unsigned(b). The 21-bit result holds every possible
  // product, so truncating the 21x21 multiply loses nothing.
  function automatic logic signed [P_W-1:0] mul_ab(
    input logic signed [A_W-1:0] a,
    input logic [B_W-1:0]        b
  );
    return P_W'(a) * P_W'($signed({1'b0, b}));
  endfunction

endpackage

// File: rtl/cnn_mul_arb_if.sv
// Requester/response bundle of cnn_mul_arb. The master side drives
// operands and the downstream ready; the slave side is the arbiter.
interface cnn_mul_arb_if #(
  parameter int NREQ = 4
) ();
  import cnn_mul_arb_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*A_W-1:0]   req_a;
  logic [NREQ*B_W-1:0]   req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic signed [P_W-1:0] rsp_p;
  logic [ID_W-1:0]       rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id
  );

endinterface

// File: rtl/cnn_mul_arb_rr.sv
// Circular-priority picker: first set bit of req_i at or above rr_ptr_i,
// wrapping around. Purely combinational.
module cnn_mul_arb_rr #(
  parameter  int NREQ  = 4,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  int               pos_s;
  logic [PTR_W-1:0] pos_idx_s;
  logic             hit_s;

  // Walk every position once starting at the pointer; the first request wins.
  always_comb begin
    grant_o   = '0;
    idx_o     = '0;
    any_o     = 1'b0;
    pos_s     = 0;
    pos_idx_s = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s            = (int'(rr_ptr_i) + k) % NREQ;
      pos_idx_s        = PTR_W'(pos_s);
      hit_s            = req_i[pos_idx_s] && !any_o;
      grant_o[pos_idx_s] = hit_s;
      idx_o            = hit_s ? pos_idx_s : idx_o;
      any_o            = any_o | req_i[pos_idx_s];
    end
  end

endmodule

// File: rtl/cnn_mul_arb.sv
// Round-robin arbiter sharing one 14x7 signed multiplier among NREQ
// requesters, with a valid/ready pipelined response.
// Optional macro CNN_MUL_ARB_OREG_EN adds an output register stage after the
// multiply stage (latency 2 instead of 1, same throughput).
module cnn_mul_arb
  import cnn_mul_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  cnn_mul_arb_if.slave     bus,
  output logic [CNT_W-1:0] issue_cnt
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  stage_t                s1_q, s1_d;
  logic [NREQ-1:0]       grant_s;
  logic [PTR_W-1:0]      gnt_idx_s;
  logic                  gnt_any_s;
  logic                  s1_ready_s;
  logic                  s1_next_ready_s;
  logic                  xfer_s;
  logic signed [A_W-1:0] a_sel_s;
  logic [B_W-1:0]        b_sel_s;

  cnn_mul_arb_rr #(.NREQ(NREQ)) u_rr (
    .req_i    (bus.req_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant_s),
    .idx_o    (gnt_idx_s),
    .any_o    (gnt_any_s)
  );

`ifdef CNN_MUL_ARB_OREG_EN
  stage_t s2_q, s2_d;
  logic   s2_ready_s;

  // Output stage takes the multiply stage whenever it is empty or drained.
  always_comb begin
    s2_ready_s = !s2_q.valid || bus.rsp_ready;
    s2_d       = s2_q;
    if (s2_ready_s) begin
      s2_d = s1_q;
    end else begin
      s2_d = s2_q;
    end
  end

  // Output stage register; reset drops any held product.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s2_q <= '0;
    end else begin
      s2_q <= s2_d;
    end
  end

  assign s1_next_ready_s = s2_ready_s;
  assign bus.rsp_valid   = s2_q.valid;
  assign bus.rsp_p       = s2_q.p;
  assign bus.rsp_id      = s2_q.id;
`else
  assign s1_next_ready_s = bus.rsp_ready;
  assign bus.rsp_valid   = s1_q.valid;
  assign bus.rsp_p       = s1_q.p;
  assign bus.rsp_id      = s1_q.id;
`endif

  // Grant only when the multiply stage can take a new operand pair and not in reset.
  always_comb begin
    s1_ready_s    = !s1_q.valid || s1_next_ready_s;
    bus.req_ready = '0;
    xfer_s        = 1'b0;
    if (s1_ready_s && !ap_rst) begin
      bus.req_ready = grant_s;
      xfer_s        = gnt_any_s;
    end else begin
      bus.req_ready = '0;
      xfer_s        = 1'b0;
    end
  end

  // Operand mux steered by the granted index.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel_s = (gnt_idx_s == PTR_W'(i)) ? bus.req_a[i*A_W +: A_W] : a_sel_s;
      b_sel_s = (gnt_idx_s == PTR_W'(i)) ? bus.req_b[i*B_W +: B_W] : b_sel_s;
    end
  end

  // Multiply stage: load on transfer, empty when drained, otherwise hold.
  always_comb begin
    s1_d = s1_q;
    if (xfer_s) begin
      s1_d.valid = 1'b1;
      s1_d.p     = mul_ab(a_sel_s, b_sel_s);
      s1_d.id    = ID_W'(gnt_idx_s);
    end else if (s1_next_ready_s) begin
      s1_d.valid = 1'b0;
    end else begin
      s1_d = s1_q;
    end
  end

  // Round-robin pointer and accepted-request counter advance on transfer.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    issue_cnt_d = issue_cnt_q;
    if (xfer_s) begin
      rr_ptr_d    = (gnt_idx_s == PTR_W'(NREQ - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end else begin
      rr_ptr_d    = rr_ptr_q;
      issue_cnt_d = issue_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr_q    <= '0;
      issue_cnt_q <= '0;
      s1_q        <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      issue_cnt_q <= issue_cnt_d;
      s1_q        <= s1_d;
    end
  end

  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_cnn_mul_arb.sv
// Directed testbench for cnn_mul_arb: product table plus round-robin,
// stall and reset sequences.
module tb_cnn_mul_arb;

`ifdef CNN_MUL_ARB_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        ap_clk;
  logic        ap_rst;
  logic [31:0] issue_cnt;
  int          checks   = 0;
  int          failures = 0;

  typedef struct {
    int id;
    int a;
    int b;
    int p;
  } vec_t;

  vec_t vecs[8];

  cnn_mul_arb_if #(.NREQ(4)) bus ();

  cnn_mul_arb #(.NREQ(4), .CNT_W(32)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .bus       (bus),
    .issue_cnt (issue_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int op_a(input int i);
    return -(i + 1) * 100;
  endfunction

  function automatic int op_b(input int i);
    return i + 10;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    bus.req_valid[i[1:0]] = 1'b1;
    bus.req_a[i*14 +: 14] = 14'(a);
    bus.req_b[i*7 +: 7]   = 7'(b);
  endtask

  task automatic all_valid();
    for (int i = 0; i < 4; i++) set_req(i, op_a(i), op_b(i));
  endtask

  task automatic do_reset();
    ap_rst        = 1'b1;
    idle();
    bus.rsp_ready = 1'b1;
    step();
    step();
    ap_rst = 1'b0;
  endtask

  initial begin
    int id;
    vecs[0] = '{0, -8192, 127, -1040384};
    vecs[1] = '{1,  8191, 127,  1040257};
    vecs[2] = '{2,    -1,   0,        0};
    vecs[3] = '{3,    -1,   1,       -1};
    vecs[4] = '{0,   100,  50,     5000};
    vecs[5] = '{2,  -300,   7,    -2100};
    vecs[6] = '{1,     0, 127,        0};
    vecs[7] = '{3,  8191,   1,     8191};

    // Reset state, with requests asserted during reset.
    ap_rst        = 1'b1;
    bus.rsp_ready = 1'b1;
    all_valid();
    step(); step(); step();
    #1;
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_issue_cnt", int'(issue_cnt), 0);
    chk("rst_rsp_p", int'(bus.rsp_p), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    idle();
    ap_rst = 1'b0;
    step();

    // Product table, one transfer at a time.
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      #1;
      chk("tbl_grant", int'(bus.req_ready), 1 << vecs[v].id);
      step();
      idle();
      repeat (LAT - 1) step();
      chk("tbl_rsp_valid", int'(bus.rsp_valid), 1);
      chk("tbl_rsp_p", int'(bus.rsp_p), vecs[v].p);
      chk("tbl_rsp_id", int'(bus.rsp_id), vecs[v].id);
      step();
      chk("tbl_rsp_drained", int'(bus.rsp_valid), 0);
      chk("tbl_issue_cnt", int'(issue_cnt), v + 1);
    end

    // All four requesting continuously: grants rotate 0,1,2,3,...
    do_reset();
    all_valid();
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("rr_grant", int'(bus.req_ready), 1 << (k % 4));
      chk("rr_issue_cnt", int'(issue_cnt), k);
      if (k >= LAT) begin
        id = (k - LAT) % 4;
        chk("rr_rsp_valid", int'(bus.rsp_valid), 1);
        chk("rr_rsp_id", int'(bus.rsp_id), id);
        chk("rr_rsp_p", int'(bus.rsp_p), op_a(id) * op_b(id));
      end
      step();
    end
    idle();
    repeat (LAT + 1) step();
    chk("rr_drained", int'(bus.rsp_valid), 0);
    chk("rr_final_cnt", int'(issue_cnt), 7);

    // Pointer after req2 transfer is 3: req0+req3 -> 3 then 0.
    do_reset();
    set_req(2, 5, 5);
    #1;
    chk("ptr_grant2", int'(bus.req_ready), 4);
    step();
    idle();
    set_req(0, 7, 3);
    set_req(3, -7, 3);
    #1;
    chk("ptr_grant3", int'(bus.req_ready), 8);
    step();
    bus.req_valid[3] = 1'b0;
    #1;
    chk("ptr_grant0", int'(bus.req_ready), 1);
    step();
    idle();
    repeat (LAT + 1) step();
    chk("ptr_issue_cnt", int'(issue_cnt), 3);

    // Downstream stall with everyone requesting.
    do_reset();
    bus.rsp_ready = 1'b0;
    all_valid();
    for (int k = 0; k < LAT; k++) begin
      #1;
      chk("stall_fill_grant", int'(bus.req_ready), 1 << k);
      step();
    end
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_rsp_valid", int'(bus.rsp_valid), 1);
      chk("stall_rsp_id", int'(bus.rsp_id), 0);
      chk("stall_rsp_p", int'(bus.rsp_p), op_a(0) * op_b(0));
      chk("stall_req_ready", int'(bus.req_ready), 0);
      chk("stall_issue_cnt", int'(issue_cnt), LAT);
      step();
    end
    bus.rsp_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      #1;
      id = r % 4;
      chk("resume_rsp_valid", int'(bus.rsp_valid), 1);
      chk("resume_rsp_id", int'(bus.rsp_id), id);
      chk("resume_rsp_p", int'(bus.rsp_p), op_a(id) * op_b(id));
      chk("resume_grant", int'(bus.req_ready), 1 << ((LAT + r) % 4));
      step();
    end
    idle();
    repeat (LAT + 1) step();
    chk("resume_drained", int'(bus.rsp_valid), 0);
    chk("resume_issue_cnt", int'(issue_cnt), LAT + 6);

    // Reset pulse with products in flight.
    do_reset();
    all_valid();
    step(); step(); step();
    ap_rst = 1'b1;
    #1;
    chk("midrst_req_ready", int'(bus.req_ready), 0);
    step();
    ap_rst = 1'b0;
    idle();
    #1;
    chk("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("midrst_issue_cnt", int'(issue_cnt), 0);
    all_valid();
    #1;
    chk("midrst_ptr_grant", int'(bus.req_ready), 1);
    step();
    idle();
    for (int j = 1; j <= LAT + 3; j++) begin
      #1;
      chk("midrst_rsp_valid_seq", int'(bus.rsp_valid), (j == LAT) ? 1 : 0);
      if (j == LAT) begin
        chk("midrst_rsp_id", int'(bus.rsp_id), 0);
        chk("midrst_rsp_p", int'(bus.rsp_p), op_a(0) * op_b(0));
      end
      step();
    end
    chk("midrst_final_cnt", int'(issue_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_mul_arb.md
CNN_MUL_ARB -- requirements
Module: cnn_mul_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the multiplier (2..8).
REQ-002 SHALL have parameter CNT_W, default 32, width of the accepted-request counter.
REQ-003 SHALL have port ap_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port ap_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port req_a  input  NREQ*14  packed signed operand a, requester i at bits [14i+13:14i].
REQ-007 SHALL have port req_b  input  NREQ*7  packed unsigned operand b, requester i at bits [7i+6:7i].
REQ-008 SHALL have port req_ready  output  NREQ  per-requester grant/accept, at most one bit set.
REQ-009 SHALL have port rsp_valid  output  1  product valid.
REQ-010 SHALL have port rsp_ready  input  1  downstream accepts product.
REQ-011 SHALL have port rsp_p  output  21  signed product.
REQ-012 SHALL have port rsp_id  output  3  index of the requester that owns rsp_p.
REQ-013 SHALL have port issue_cnt  output  CNT_W  count of accepted requests, wraps modulo 2^CNT_W.

Function
REQ-014 Product SHALL be exact: rsp_p = signed(a) * signed({1'b0,b}), 21 bits, no truncation or saturation.
REQ-015 Transfer on requester i SHALL occur when req_valid[i] && req_ready[i]; requesters hold valid and operands stable until transfer.
REQ-016 req_ready SHALL be all zero when the issue stage cannot accept (issue stage holds a product and is not advancing).
REQ-017 Otherwise req_ready SHALL be one-hot on the first valid requester searching circularly from rr_ptr upward; all zero if none valid.
REQ-018 req_ready MAY depend combinationally on req_valid; req_valid SHALL NOT depend on req_ready.
REQ-019 rr_ptr (log2 NREQ bits) SHALL update to (granted index + 1) mod NREQ on transfer, else hold.
REQ-020 Each pipeline stage SHALL advance when it is empty or its successor accepts (stage ready = !valid || next ready); output stage's successor is rsp_ready.
REQ-021 Sustained throughput SHALL be one product per cycle when rsp_ready stays high.
REQ-022 While rsp_valid && !rsp_ready, rsp_valid, rsp_p and rsp_id SHALL hold stable.
REQ-023 rsp_id SHALL travel with its product through every stage; responses SHALL leave in acceptance order.
REQ-024 issue_cnt SHALL increment by 1 on each transfer, wrapping from all-ones to 0.

Reset
REQ-025 During ap_rst, rr_ptr, issue_cnt, rsp_p, rsp_id and all stage valid flags SHALL clear to 0; req_ready SHALL be 0.
REQ-026 In-flight products SHALL be discarded on reset mid-operation; no response for them appears after reset.

Configuration
REQ-027 Macro CNN_MUL_ARB_OREG_EN SHALL add a second register stage after the multiply stage.
REQ-028 Without CNN_MUL_ARB_OREG_EN: rsp_valid asserts the cycle after transfer (latency 1).
REQ-029 With CNN_MUL_ARB_OREG_EN: rsp_valid asserts two cycles after transfer (latency 2), throughput per REQ-021 unchanged.

Structure
REQ-030 Package cnn_mul_arb_pkg SHALL hold A_W=14, B_W=7, P_W=21, ID_W=3 and the stage struct (valid, p, id).
REQ-031 Circular-priority picker SHALL be sub-module cnn_mul_arb_rr (inputs req vector, rr_ptr; outputs one-hot grant, index).
REQ-032 Multiply SHALL be a single registered expression mapping to one DSP48; no other multipliers.

Verification
REQ-033 req0 a=-8192 b=127, rsp_ready=1 -> rsp_p=-1040384, rsp_id=0, one cycle later (two with OREG); issue_cnt=1.
REQ-034 a=8191 b=127 -> rsp_p=1040257; a=-1 b=0 -> rsp_p=0; a=-1 b=1 -> rsp_p=-1.
REQ-035 All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, rsp_id same sequence.
REQ-036 After reset, req2 transfers (rr_ptr=3), then req0 and req3 valid together -> grant 3 then 0.
REQ-037 rsp_ready low 3 cycles with product pending, all req_valid high -> rsp held, req_ready all 0 once pipeline full (0 at once without OREG), issue_cnt frozen; resumes in order with no loss or duplication.
REQ-038 ap_rst pulsed with products in flight -> next cycle rsp_valid=0, issue_cnt=0, rr_ptr=0; no stale responses afterward.
